// File: rtl/cnt_mon_pkg.sv
// Shared definitions for the counter event monitor: flag layout and entry format.
package cnt_mon_pkg;

    localparam int CNT_W = 4;   // default observed count width
    localparam int EVT_W = 4;   // number of event flag bits

    // Bit positions inside the event flag vector
    localparam int EVT_WRAP_UP   = 0;
    localparam int EVT_WRAP_DOWN = 1;
    localparam int EVT_JUMP      = 2;
    localparam int EVT_MATCH     = 3;

    // One queued event at the default count width
    typedef struct packed {
        logic [EVT_W-1:0] flags;
        logic [CNT_W-1:0] count;
    } evt_entry_t;

endpackage

// File: rtl/event_fifo.sv
// Small power-of-two FIFO; a push into a full FIFO is accepted only when a pop
// frees a slot in the same cycle, otherwise it is dropped and reported.
module event_fifo #(
    parameter  int DW    = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          drop
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          push_acc, pop_acc;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (AW+1)'(DEPTH));
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);
    assign drop     = push && !push_acc;
    assign level    = level_q;
    // Empty FIFO presents zeros rather than stale storage
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_acc && !pop_acc)      level_d = level_q + 1'b1;
        else if (pop_acc && !push_acc) level_d = level_q - 1'b1;
    end

    // Control state, cleared asynchronously so queued events vanish on reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: it is only visible while level is non-zero
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/count_event_monitor.sv
// Observes a counter value every cycle, classifies each transition and queues
// the resulting events for a valid/ready consumer.
module count_event_monitor
    import cnt_mon_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         count_in,
    input  logic                     cmp_en,
    input  logic [WIDTH-1:0]         cmp_value,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [EVT_W-1:0]         evt_flags,
    output logic [WIDTH-1:0]         evt_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam logic [WIDTH-1:0] MAX = '1;

    typedef struct packed {
        logic [EVT_W-1:0] flags;
        logic [WIDTH-1:0] count;
    } entry_t;

    logic [WIDTH-1:0] prev_q;
    logic             prev_vld_q;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] delta;
    logic [EVT_W-1:0] flags;
    entry_t           push_e, head_e;
    logic             fifo_full, fifo_empty, fifo_drop;

    // Transition classification against the previous sample; only MATCH is
    // meaningful before the first sample has been taken
    always_comb begin
        flags = '0;
        delta = count_in - prev_q;
        if (prev_vld_q) begin
            flags[EVT_WRAP_UP]   = (prev_q == MAX) && (count_in == '0);
            flags[EVT_WRAP_DOWN] = (prev_q == '0)  && (count_in == MAX);
            flags[EVT_JUMP]      = (delta != '0) && (delta != WIDTH'(1)) && (delta != MAX);
        end
        flags[EVT_MATCH] = cmp_en && (count_in == cmp_value) &&
                           ((count_in != prev_q) || !prev_vld_q);
    end

    assign push_e = '{flags: flags, count: count_in};

    event_fifo #(
        .DW    ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (|flags),
        .wr_data (push_e),
        .pop     (evt_ready),
        .rd_data (head_e),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .drop    (fifo_drop)
    );

    assign evt_valid = !fifo_empty;
    assign evt_flags = head_e.flags;
    assign evt_count = head_e.count;
    assign overflow  = overflow_q;

    // Sticky overflow: a drop in the same cycle as a clear keeps it set
    always_comb begin
        overflow_d = overflow_q;
        if (fifo_drop && fifo_full) overflow_d = 1'b1;
        else if (ovf_clr)           overflow_d = 1'b0;
    end

    // Previous-sample and overflow registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= count_in;
            prev_vld_q <= 1'b1;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_count_event_monitor.sv
// Bench for count_event_monitor: directed vector table, a reset-mid-queue
// sequence, and randomized traffic against a queue-based reference model.
module tb_count_event_monitor;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] count_in;
    logic       cmp_en;
    logic [3:0] cmp_value;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_flags;
    logic [3:0] evt_count;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       ovf_clr;

    count_event_monitor #(.WIDTH(4), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .count_in   (count_in),
        .cmp_en     (cmp_en),
        .cmp_value  (cmp_value),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_flags  (evt_flags),
        .evt_count  (evt_count),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: queue of {flags, count}, last sample, sticky flag
    logic [7:0] mq[$];
    logic [3:0] m_prev;
    logic       m_vld;
    logic       m_ovf;

    typedef struct {
        logic [3:0] cnt; logic ce; logic [3:0] cv; logic rdy; logic oc;
        logic ev; logic [3:0] ef; logic [3:0] ec; logic [2:0] el; logic eo;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_prev = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " valid"},    int'(evt_valid),  int'(mq.size() > 0));
        chk({tag, " flags"},    int'(evt_flags),  mq.size() > 0 ? int'(mq[0][7:4]) : 0);
        chk({tag, " count"},    int'(evt_count),  mq.size() > 0 ? int'(mq[0][3:0]) : 0);
        chk({tag, " level"},    int'(fifo_level), mq.size());
        chk({tag, " overflow"}, int'(overflow),   int'(m_ovf));
    endtask

    // Apply one cycle of inputs, advance the model by the specification's
    // rules, then compare after the clock edge.
    task automatic step(input logic [3:0] c, input logic ce, input logic [3:0] cv,
                        input logic rdy, input logic oc, input string tag);
        logic [3:0] f;
        int         d;
        logic       pop, drop;
        count_in  = c;
        cmp_en    = ce;
        cmp_value = cv;
        evt_ready = rdy;
        ovf_clr   = oc;
        f = '0;
        if (m_vld) begin
            d = (int'(c) - int'(m_prev) + 16) % 16;
            f[0] = (m_prev == 4'd15) && (c == 4'd0);
            f[1] = (m_prev == 4'd0)  && (c == 4'd15);
            f[2] = (d != 0) && (d != 1) && (d != 15);
        end
        f[3] = ce && (c == cv) && (!m_vld || c != m_prev);
        pop  = rdy && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        drop = 1'b0;
        if (f != 0) begin
            if (mq.size() < DEPTH) mq.push_back({f, c});
            else drop = 1'b1;
        end
        if (drop)    m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        m_prev = c;
        m_vld  = 1'b1;
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    task automatic add(input logic [3:0] c, input logic ce, input logic [3:0] cv,
                       input logic rdy, input logic oc, input logic ev,
                       input logic [3:0] ef, input logic [3:0] ec,
                       input logic [2:0] el, input logic eo);
        vec_t v;
        v = '{c, ce, cv, rdy, oc, ev, ef, ec, el, eo};
        tbl.push_back(v);
    endtask

    initial begin
        reset_n   = 1'b0;
        count_in  = '0;
        cmp_en    = 1'b0;
        cmp_value = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #12;
        chk("reset valid",    int'(evt_valid),  0);
        chk("reset flags",    int'(evt_flags),  0);
        chk("reset count",    int'(evt_count),  0);
        chk("reset level",    int'(fifo_level), 0);
        chk("reset overflow", int'(overflow),   0);
        reset_n = 1'b1;

        //   cnt  ce cv   rdy oc | v  flags    cnt  lvl ovf
        // steady +1 stepping, compare disabled: nothing queued
        for (int i = 0; i < 6; i++) add(4'(i), 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
        add(14, 0, 0, 1, 0, 1, 4'b0100, 14, 1, 0);  // 5 -> 14 is a jump
        add(15, 0, 0, 1, 0, 0, 4'b0000,  0, 0, 0);  // popped, +1 step
        add( 0, 1, 0, 1, 0, 1, 4'b1001,  0, 1, 0);  // wrap-up plus match
        add( 0, 1, 0, 1, 0, 0, 4'b0000,  0, 0, 0);  // holding on match value
        add(15, 0, 0, 1, 0, 1, 4'b0010, 15, 1, 0);  // wrap-down
        add( 3, 0, 0, 1, 0, 1, 4'b0100,  3, 1, 0);
        add( 9, 0, 0, 1, 0, 1, 4'b0100,  9, 1, 0);  // load 3 -> 9
        add( 9, 0, 0, 1, 0, 0, 4'b0000,  0, 0, 0);
        // fill with jumps, consumer stalled, fifth one dropped
        add( 1, 0, 0, 0, 0, 1, 4'b0100,  1, 1, 0);
        add( 5, 0, 0, 0, 0, 1, 4'b0100,  1, 2, 0);
        add(10, 0, 0, 0, 0, 1, 4'b0100,  1, 3, 0);
        add( 2, 0, 0, 0, 0, 1, 4'b0100,  1, 4, 0);
        add( 7, 0, 0, 0, 0, 1, 4'b0100,  1, 4, 1);
        add( 7, 0, 0, 0, 1, 1, 4'b0100,  1, 4, 0);  // clear overflow
        add(12, 0, 0, 1, 0, 1, 4'b0100,  5, 4, 0);  // full: pop + push
        add(12, 0, 0, 1, 0, 1, 4'b0100, 10, 3, 0);  // drain in order
        add(12, 0, 0, 1, 0, 1, 4'b0100,  2, 2, 0);
        add(12, 0, 0, 1, 0, 1, 4'b0100, 12, 1, 0);
        add(12, 0, 0, 1, 0, 0, 4'b0000,  0, 0, 0);
        // refill, then drop coinciding with a clear: set wins
        add( 0, 0, 0, 0, 0, 1, 4'b0100,  0, 1, 0);
        add( 8, 0, 0, 0, 0, 1, 4'b0100,  0, 2, 0);
        add( 1, 0, 0, 0, 0, 1, 4'b0100,  0, 3, 0);
        add( 6, 0, 0, 0, 0, 1, 4'b0100,  0, 4, 0);
        add(11, 0, 0, 0, 1, 1, 4'b0100,  0, 4, 1);
        add(11, 0, 0, 0, 1, 1, 4'b0100,  0, 4, 0);
        add(11, 0, 0, 1, 0, 1, 4'b0100,  8, 3, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].cnt, tbl[i].ce, tbl[i].cv, tbl[i].rdy, tbl[i].oc, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl valid", i), int'(evt_valid),  int'(tbl[i].ev));
            chk($sformatf("vec%0d tbl flags", i), int'(evt_flags),  int'(tbl[i].ef));
            chk($sformatf("vec%0d tbl count", i), int'(evt_count),  int'(tbl[i].ec));
            chk($sformatf("vec%0d tbl level", i), int'(fifo_level), int'(tbl[i].el));
            chk($sformatf("vec%0d tbl ovf",   i), int'(overflow),   int'(tbl[i].eo));
        end

        // Asynchronous reset with three events queued, away from any edge
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst valid", int'(evt_valid),  0);
        chk("midrst level", int'(fifo_level), 0);
        chk("midrst flags", int'(evt_flags),  0);
        chk("midrst ovf",   int'(overflow),   0);
        model_reset();
        #2;
        reset_n = 1'b1;
        // First sample equals compare value: MATCH alone, no jump from 0
        step(6, 1, 6, 0, 0, "post-rst match");
        chk("post-rst flags", int'(evt_flags), 8);
        chk("post-rst count", int'(evt_count), 6);
        step(6, 1, 6, 1, 0, "post-rst hold");

        // Randomized traffic with stall phases to exercise full/overflow
        for (int i = 0; i < 400; i++) begin
            logic [3:0] c;
            int         r;
            logic       rdy;
            r = int'($urandom_range(0, 7));
            if (r < 3)       c = m_prev + 4'd1;
            else if (r < 5)  c = m_prev - 4'd1;
            else if (r == 5) c = m_prev;
            else             c = 4'($urandom_range(0, 15));
            if ((i / 50) % 2 == 1) rdy = ($urandom_range(0, 5) == 0);
            else                   rdy = ($urandom_range(0, 3) != 0);
            step(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), rdy,
                 ($urandom_range(0, 15) == 0), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
